// File: rtl/clint_vec_if.sv
// Bundle between the core and the clint_vec interrupt controller.
// The slave modport is the controller. The master modport is the core, or a bench standing in for it.
interface clint_vec_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_en_i;
    logic [31:0]        inst_i;
    logic [31:0]        inst_addr_i;
    logic               jump_flag_i;
    logic [31:0]        jump_addr_i;
    logic               div_started_i;
    logic [31:0]        csr_mtvec;
    logic [31:0]        csr_mepc;
    logic [31:0]        csr_mstatus;
    logic               hold_flag_o;
    logic               we_o;
    logic [31:0]        waddr_o;
    logic [31:0]        data_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;
    logic [4:0]         int_id_o;

    modport master (
        output irq_i, irq_en_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
               div_started_i, csr_mtvec, csr_mepc, csr_mstatus,
        input  hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o, int_id_o
    );

    modport slave (
        input  irq_i, irq_en_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
               div_started_i, csr_mtvec, csr_mepc, csr_mstatus,
        output hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o, int_id_o
    );
endinterface

// File: rtl/clint_vec.sv
// Core-local interrupt controller: it arbitrates irq lines at fixed priority and handles ecall/ebreak/mret.
// It sequences the trap CSR writes. Define CLINT_VECTORED_EN to enable vectored mtvec for async traps.
module clint_vec #(
    parameter int NUM_IRQ     = 8,
    parameter int CAUSE_BASE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    clint_vec_if.slave  bus
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MRET
    } state_t;

    state_t             state;
    logic [31:0]        mepc_q;
    logic [31:0]        cause_q;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

    // NOTE: sequential state is written with <= so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] eligible;
    logic [4:0]         win_id;

    assign irq_s    = sync_q[SYNC_STAGES-1];
    assign eligible = irq_s & bus.irq_en_i & {NUM_IRQ{bus.csr_mstatus[3]}};

    // NOTE: give every combinational output a default first so that no path infers a latch.
    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = 5'(i);
        end
    end

    logic is_ecall, is_ebreak, is_mret, sample_ok;
    logic take_sync, take_async, take_mret;

    assign is_ecall  = (bus.inst_i == INST_ECALL);
    assign is_ebreak = (bus.inst_i == INST_EBREAK);
    assign is_mret   = (bus.inst_i == INST_MRET);

    // The redirect cycle is not a sampling slot, even though the FSM is already back in IDLE.
    assign sample_ok  = (state == S_IDLE) && !bus.int_assert_o;
    assign take_sync  = sample_ok && (is_ecall || is_ebreak) && !bus.div_started_i;
    assign take_async = sample_ok && !take_sync && (|eligible);
    assign take_mret  = sample_ok && !take_sync && !(|eligible) && is_mret;

    assign bus.hold_flag_o = take_sync || take_async || take_mret
                          || (state != S_IDLE) || bus.int_assert_o;

    logic [31:0] sync_mepc, async_mepc, async_cause;
    logic [31:0] mstatus_trap, mstatus_mret;
    logic [31:0] trap_base, trap_target;

    assign sync_mepc   = bus.jump_flag_i ? bus.jump_addr_i - 32'd4 : bus.inst_addr_i;
    assign async_mepc  = bus.jump_flag_i   ? bus.jump_addr_i :
                         bus.div_started_i ? bus.inst_addr_i - 32'd4 : bus.inst_addr_i;
    assign async_cause = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(win_id));

    always_comb begin
        mstatus_trap    = bus.csr_mstatus;
        mstatus_trap[7] = bus.csr_mstatus[3];
        mstatus_trap[3] = 1'b0;
        mstatus_mret    = bus.csr_mstatus;
        mstatus_mret[3] = bus.csr_mstatus[7];
        mstatus_mret[7] = 1'b1;
    end

    assign trap_base = {bus.csr_mtvec[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
    // cause_q[31] marks an async trap. Only async traps take the vectored offset.
    assign trap_target = (cause_q[31] && bus.csr_mtvec[1:0] == 2'b01)
                       ? trap_base + ((32'(CAUSE_BASE) + 32'(bus.int_id_o)) << 2)
                       : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.csr_mtvec[1:0];
    assign trap_target       = trap_base;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            mepc_q           <= '0;
            cause_q          <= '0;
            bus.we_o         <= 1'b0;
            bus.waddr_o      <= '0;
            bus.data_o       <= '0;
            bus.int_assert_o <= 1'b0;
            bus.int_addr_o   <= '0;
            bus.int_id_o     <= '0;
        end else begin
            bus.we_o         <= 1'b0;
            bus.waddr_o      <= '0;
            bus.data_o       <= '0;
            bus.int_assert_o <= 1'b0;
            bus.int_addr_o   <= '0;
            case (state)
                S_IDLE: begin
                    if (take_sync) begin
                        mepc_q  <= sync_mepc;
                        cause_q <= is_ecall ? 32'd11 : 32'd3;
                        state   <= S_MEPC;
                    end else if (take_async) begin
                        mepc_q       <= async_mepc;
                        cause_q      <= async_cause;
                        bus.int_id_o <= win_id;
                        state        <= S_MEPC;
                    end else if (take_mret) begin
                        state <= S_MRET;
                    end
                end
                S_MEPC: begin
                    bus.we_o    <= 1'b1;
                    bus.waddr_o <= CSR_MEPC;
                    bus.data_o  <= mepc_q;
                    state       <= S_MSTATUS;
                end
                S_MSTATUS: begin
                    bus.we_o    <= 1'b1;
                    bus.waddr_o <= CSR_MSTATUS;
                    bus.data_o  <= mstatus_trap;
                    state       <= S_MCAUSE;
                end
                S_MCAUSE: begin
                    bus.we_o         <= 1'b1;
                    bus.waddr_o      <= CSR_MCAUSE;
                    bus.data_o       <= cause_q;
                    bus.int_assert_o <= 1'b1;
                    bus.int_addr_o   <= trap_target;
                    state            <= S_IDLE;
                end
                S_MRET: begin
                    bus.we_o         <= 1'b1;
                    bus.waddr_o      <= CSR_MSTATUS;
                    bus.data_o       <= mstatus_mret;
                    bus.int_assert_o <= 1'b1;
                    bus.int_addr_o   <= bus.csr_mepc;
                    state            <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_vec.sv
// Directed bench for clint_vec. It uses hand-computed CSR write sequences, redirect targets and latencies.
// The vectored-target expectation follows CLINT_VECTORED_EN.
module tb_clint_vec;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    clint_vec_if #(.NUM_IRQ(8)) bus ();

    clint_vec #(.NUM_IRQ(8), .CAUSE_BASE(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_we"}, 32'(bus.we_o), 32'd1);
        check({tag, "_waddr"}, bus.waddr_o, addr);
        check({tag, "_data"}, bus.data_o, data);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, 32'(bus.we_o), 32'd0);
        check({tag, "_assert"}, 32'(bus.int_assert_o), 32'd0);
    endtask

    // Waits up to a fixed number of cycles for the first CSR write and reports how many cycles it took.
    task automatic wait_we(input string tag, output int cycles);
        cycles = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cycles++;
            if (bus.we_o) break;
        end
        if (!bus.we_o) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic watch_idle(input string tag, input int n);
        logic seen_hold, seen_we;
        seen_hold = 1'b0;
        seen_we   = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen_hold |= bus.hold_flag_o;
            seen_we   |= bus.we_o;
        end
        check({tag, "_hold"}, 32'(seen_hold), 32'd0);
        check({tag, "_we"}, 32'(seen_we), 32'd0);
    endtask

    int lat;
    logic [31:0] vec_target;

    initial begin
        bus.irq_i         = '0;
        bus.irq_en_i      = '0;
        bus.inst_i        = NOP;
        bus.inst_addr_i   = '0;
        bus.jump_flag_i   = 1'b0;
        bus.jump_addr_i   = '0;
        bus.div_started_i = 1'b0;
        bus.csr_mtvec     = 32'h0000_1000;
        bus.csr_mepc      = '0;
        bus.csr_mstatus   = '0;

        repeat (2) tick();
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_hold", 32'(bus.hold_flag_o), 32'd0);
        check("rst_id", 32'(bus.int_id_o), 32'd0);
        rst = 1'b1;
        tick();

        // Lines 2 and 5 are both pending. Line 2 has the lower index and wins.
        bus.irq_i       = 8'b0010_0100;
        bus.irq_en_i    = 8'hFF;
        bus.csr_mstatus = 32'h8;
        bus.inst_addr_i = 32'h100;
        wait_we("async", lat);
        check("async_latency", 32'(lat), 32'd4);
        check_write("async_mepc", 32'h341, 32'h100);
        bus.irq_i = 8'h01;
        tick();
        check_write("async_mstatus", 32'h300, 32'h80);
        bus.csr_mstatus = 32'h80;
        bus.irq_i       = '0;
        tick();
        check_write("async_mcause", 32'h342, 32'h8000_0012);
        check("async_assert", 32'(bus.int_assert_o), 32'd1);
        check("async_addr", bus.int_addr_o, 32'h1000);
        check("async_id", 32'(bus.int_id_o), 32'd2);
        tick();
        check_quiet("async_after");
        check("async_after_addr", bus.int_addr_o, 32'h0);
        repeat (3) tick();

        // Line 2 is masked by irq_en_i. Then it is enabled but MIE is clear.
        bus.irq_i       = 8'h04;
        bus.irq_en_i    = 8'hFB;
        bus.csr_mstatus = 32'h8;
        watch_idle("masked_en", 6);
        bus.irq_en_i    = 8'hFF;
        bus.csr_mstatus = 32'h0;
        watch_idle("masked_mie", 6);
        bus.irq_i = '0;
        repeat (3) tick();

        // ecall while ex is jumping. mtvec mode 1 still gives the base address for sync traps.
        bus.csr_mtvec   = 32'h0000_1001;
        bus.csr_mstatus = 32'h8;
        bus.inst_i      = ECALL;
        bus.inst_addr_i = 32'h300;
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h200;
        #1;
        check("ecall_hold_comb", 32'(bus.hold_flag_o), 32'd1);
        tick();
        bus.inst_i      = NOP;
        bus.jump_flag_i = 1'b0;
        check_quiet("ecall_accept");
        tick();
        check_write("ecall_mepc", 32'h341, 32'h1FC);
        tick();
        check_write("ecall_mstatus", 32'h300, 32'h80);
        bus.csr_mstatus = 32'h80;
        tick();
        check_write("ecall_mcause", 32'h342, 32'd11);
        check("ecall_assert", 32'(bus.int_assert_o), 32'd1);
        check("ecall_addr", bus.int_addr_o, 32'h1000);
        check("ecall_id_held", 32'(bus.int_id_o), 32'd2);
        tick();
        check_quiet("ecall_after");

        // The ebreak is held off while the divider is busy.
        bus.csr_mstatus   = 32'h0;
        bus.inst_i        = EBREAK;
        bus.inst_addr_i   = 32'h400;
        bus.div_started_i = 1'b1;
        watch_idle("ebreak_div", 4);
        bus.div_started_i = 1'b0;
        #1;
        check("ebreak_hold_comb", 32'(bus.hold_flag_o), 32'd1);
        wait_we("ebreak", lat);
        bus.inst_i = NOP;
        check("ebreak_latency", 32'(lat), 32'd2);
        check_write("ebreak_mepc", 32'h341, 32'h400);
        tick();
        check_write("ebreak_mstatus", 32'h300, 32'h0);
        tick();
        check_write("ebreak_mcause", 32'h342, 32'd3);
        check("ebreak_assert", 32'(bus.int_assert_o), 32'd1);
        tick();

        // mret restores MIE from MPIE. The redirect goes out two cycles after acceptance.
        bus.csr_mstatus = 32'h80;
        bus.csr_mepc    = 32'h1FC;
        bus.inst_i      = MRET;
        #1;
        check("mret_hold_comb", 32'(bus.hold_flag_o), 32'd1);
        tick();
        bus.inst_i = NOP;
        check_quiet("mret_accept");
        tick();
        check_write("mret_mstatus", 32'h300, 32'h88);
        check("mret_assert", 32'(bus.int_assert_o), 32'd1);
        check("mret_addr", bus.int_addr_o, 32'h1FC);
        tick();
        check_quiet("mret_after");
        check("mret_after_hold", 32'(bus.hold_flag_o), 32'd0);

        // Line 3 with mtvec in vectored mode.
`ifdef CLINT_VECTORED_EN
        vec_target = 32'h104C;
`else
        vec_target = 32'h1000;
`endif
        bus.csr_mtvec   = 32'h0000_1001;
        bus.csr_mstatus = 32'h8;
        bus.irq_i       = 8'h08;
        wait_we("vec", lat);
        check_write("vec_mepc", 32'h341, 32'h400);
        tick();
        bus.csr_mstatus = 32'h80;
        bus.irq_i       = '0;
        tick();
        check_write("vec_mcause", 32'h342, 32'h8000_0013);
        check("vec_addr", bus.int_addr_o, vec_target);
        check("vec_id", 32'(bus.int_id_o), 32'd3);
        repeat (3) tick();

        // Reset lands in the middle of a MEPC write.
        bus.csr_mstatus = 32'h0;
        bus.inst_i      = ECALL;
        tick();
        bus.inst_i = NOP;
        tick();
        check("rst_mid_we_before", 32'(bus.we_o), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_we", 32'(bus.we_o), 32'd0);
        check("rst_mid_waddr", bus.waddr_o, 32'h0);
        check("rst_mid_data", bus.data_o, 32'h0);
        check("rst_mid_id", 32'(bus.int_id_o), 32'd0);
        check("rst_mid_hold", 32'(bus.hold_flag_o), 32'd0);
        tick();
        rst = 1'b1;
        watch_idle("rst_release", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
